// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic array blocks: accumulator width,
// default array width, collector state encoding and a width helper.
package tpu_pkg;

    localparam int TPU_ACC_W = 32;
    localparam int TPU_N     = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/collector_row_buffer.sv
// ROWS x N result store. Each column writes on its own diagonal slot
// (row = t - LAT - j) and one combinational port reads a whole row.
module collector_row_buffer #(
    parameter int N     = 4,
    parameter int ROWS  = 4,
    parameter int ACC_W = 32,
    parameter int LAT   = 2,
    parameter int CW    = 4,
    parameter int RW    = 2
) (
    input  logic                 clk,
    input  logic                 capture,
    input  logic [CW-1:0]        t,
    input  logic [N*ACC_W-1:0]   c_in,
    input  logic [RW-1:0]        rd_row,
    output logic [N*ACC_W-1:0]   rd_data
);

    for (genvar j = 0; j < N; j++) begin : g_col
        localparam logic [CW-1:0] LO = CW'(LAT + j);
        localparam logic [CW-1:0] HI = CW'(LAT + j + ROWS);

        logic [ACC_W-1:0] col_mem [ROWS];
        logic             wen;
        logic [CW-1:0]    offs;

        // Column j sees row r exactly j edges after column 0 does.
        assign offs = t - LO;
        assign wen  = capture && (t >= LO) && (t < HI);

        always_ff @(posedge clk) begin
            if (wen) col_mem[RW'(offs)] <= c_in[j*ACC_W +: ACC_W];
        end

        assign rd_data[j*ACC_W +: ACC_W] = col_mem[rd_row];
    end

endmodule

// File: rtl/systolic_result_collector.sv
// Drain-side collector: de-skews the bottom-row c_out wavefront into whole
// rows and streams them out one row per valid/ready transfer.
module systolic_result_collector
    import tpu_pkg::*;
#(
    parameter int N     = TPU_N,
    parameter int ROWS  = 4,
    parameter int ACC_W = TPU_ACC_W,
    parameter int LAT   = 2,
    localparam int RW   = (clog2(ROWS) > 0) ? clog2(ROWS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N*ACC_W-1:0] c_in,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*ACC_W-1:0] out_data,
    output logic [RW-1:0]      out_row,
    output logic               out_last,
    output logic               done
);

    localparam int            CW       = clog2(LAT + ROWS + N);
    localparam logic [CW-1:0] LAST_T   = CW'(LAT + ROWS + N - 2);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        t;
    logic [RW-1:0]        ptr;
    logic                 done_nxt;
    logic [N*ACC_W-1:0]   rd_data;

    // cnt is cleared on the accepting edge, so the edge about to happen is cnt+1.
    assign t = cnt + CW'(1);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (t == LAST_T) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (out_ready && ptr == LAST_ROW) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ptr   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    ptr <= '0;
                end
                ST_CAPTURE: cnt <= t;
                ST_DRAIN:   if (out_ready && ptr != LAST_ROW) ptr <= ptr + RW'(1);
                default: ;
            endcase
        end
    end

    collector_row_buffer #(
        .N     (N),
        .ROWS  (ROWS),
        .ACC_W (ACC_W),
        .LAT   (LAT),
        .CW    (CW),
        .RW    (RW)
    ) u_buf (
        .clk     (clk),
        .capture (state == ST_CAPTURE),
        .t       (t),
        .c_in    (c_in),
        .rd_row  (ptr),
        .rd_data (rd_data)
    );

    // Outputs are forced to zero outside DRAIN so the buffer's power-up
    // contents never reach the port.
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DRAIN);
    assign out_last  = out_valid && (ptr == LAST_ROW);
    assign out_data  = out_valid ? rd_data : '0;
    assign out_row   = out_valid ? ptr : '0;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed bench for systolic_result_collector with N=4, ROWS=4, LAT=2.
module tb_systolic_result_collector;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] c_in;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [1:0]   out_row;
    logic         out_last;
    logic         done;

    int n_chk  = 0;
    int n_fail = 0;

    systolic_result_collector #(.N(4), .ROWS(4), .ACC_W(32), .LAT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .c_in      (c_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] val(input int r, input int j, input int mode);
        if (mode == 1) return 32'hFFFF_FFFF;
        return 32'(100 * r + j);
    endfunction

    function automatic logic [127:0] exp_row(input int r, input int mode);
        logic [127:0] v;
        v = '0;
        for (int j = 0; j < 4; j++) v[j*32 +: 32] = val(r, j, mode);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts a job at E0 and drives the skewed wavefront up to E8.
    task automatic capture(input int mode, input bit extra_start);
        start = 1'b1;
        c_in  = {4{32'hDEAD_BEEF}};
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
        for (int k = 1; k <= 8; k++) begin
            for (int j = 0; j < 4; j++) begin
                int r;
                r = k - 2 - j;
                c_in[j*32 +: 32] = (r >= 0 && r < 4) ? val(r, j, mode) : 32'hDEAD_BEEF;
            end
            start = extra_start && (k == 3);
            tick();
            start = 1'b0;
            chk("busy_capture", busy, 1);
            if (k < 8) chk("valid_capture", out_valid, 0);
        end
        c_in = {4{32'hDEAD_BEEF}};
    endtask

    task automatic drain(input int mode, input int stall_row, input int stall_cycles,
                         input bit extra_start);
        int er;
        int stalled;
        int hs;
        er = 0;
        stalled = 0;
        hs = 0;
        for (int cyc = 0; cyc < 40 && er < 4; cyc++) begin
            chk("out_valid", out_valid, 1);
            chk("out_row", out_row, er);
            chk("out_data", out_data, exp_row(er, mode));
            chk("out_last", out_last, er == 3);
            chk("done_in_drain", done, 0);
            chk("busy_drain", busy, 1);
            if (er == stall_row && stalled < stall_cycles) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
            start = extra_start && (er == 2);
            tick();
            start = 1'b0;
            if (out_ready) begin
                er++;
                hs++;
            end
        end
        out_ready = 1'b0;
        chk("handshakes", hs, 4);
        chk("done_pulse", done, 1);
        chk("busy_after_drain", busy, 0);
        chk("valid_after_drain", out_valid, 0);
        chk("last_after_drain", out_last, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        c_in      = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        chk("rst_row", out_row, 0);
        reset = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // plain job
        capture(0, 1'b0);
        drain(0, -1, 0, 1'b0);
        tick();
        chk("done_once_s2", done, 0);

        // back-pressure on row 1
        capture(0, 1'b0);
        drain(0, 1, 5, 1'b0);
        tick();
        chk("done_once_s3", done, 0);

        // start pulses while busy are ignored
        capture(0, 1'b1);
        drain(0, -1, 0, 1'b1);
        tick();
        chk("done_once_s4", done, 0);
        chk("idle_after_s4", busy, 0);

        // reset while row 1 is presented
        capture(0, 1'b0);
        chk("s5_row0", out_row, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("s5_row1", out_row, 1);
        chk("s5_data1", out_data, exp_row(1, 0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("s5_valid", out_valid, 0);
        chk("s5_busy", busy, 0);
        chk("s5_done", done, 0);
        chk("s5_data", out_data, 0);
        tick();
        chk("s5_done_late", done, 0);
        chk("s5_idle", busy, 0);
        capture(0, 1'b0);
        drain(0, -1, 0, 1'b0);
        tick();

        // all-ones samples, then a second job started in the done cycle
        capture(1, 1'b0);
        drain(1, -1, 0, 1'b0);
        capture(0, 1'b0);
        drain(0, 2, 2, 1'b0);
        tick();
        chk("done_once_s6", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
